// File: rtl/pix_capture_pkg.sv
// Shared types for the pixel capture path: FSM states, pixel formats and the
// FIFO entry layout carried from the assembler to the video stage.
package pix_capture_pkg;

  localparam int PIX_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS_HI,
    WAIT_VS_LO,
    ACTIVE
  } state_e;

  typedef enum logic {
    MODE_RGB444,
    MODE_RGB565
  } mode_e;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/pix_fifo_sync.sv
// Single-clock first-word-fall-through FIFO; the head entry is visible on dout_o
// while not empty, and a push into a full FIFO is taken when a pop happens too.
module pix_fifo_sync #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pix_capture.sv
// Camera byte-stream capture: RGB444/RGB565 assembly, power-of-two decimation,
// SOF/EOL tagging and an output FIFO. Statistics counters need PIX_CAPTURE_STATS_EN.
module pix_capture
  import pix_capture_pkg::*;
#(
  parameter int RL         = 640,
  parameter int ROW        = 480,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_mode,
  input  logic [1:0]    i_decim,
  input  logic          i_vsync,
  input  logic          i_href,
  input  logic [7:0]    i_pix_byte,
  input  logic          i_ovf_clr,
  input  logic          i_data_ready,
  output logic          o_data_valid,
  output logic [DW-1:0] o_data,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_overflow,
  output logic [15:0]   o_frame_cnt,
  output logic [15:0]   o_drop_cnt
);

  localparam int CW = $clog2(RL + 1);
  localparam int RW = $clog2(ROW + 1);
  localparam logic [CW-1:0] RL_C  = CW'(RL);
  localparam logic [RW-1:0] ROW_C = RW'(ROW);

  state_e      state_q;
  mode_e       mode_q;
  logic [1:0]  decim_q;
  logic        vsync_q, href_q, vsync_prev_q, href_prev_q;
  logic [7:0]  byte_q, byte1_q;
  logic        phase_q, sof_pend_q, overflow_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic        vs_rise, href_rise, href_fall, capturing, pix_done, keep, pix_push;
  logic        pop_fire, drop, fifo_full, fifo_empty;
  logic [3:0]  step;
  logic [15:0] pix_data;
  pix_entry_t  push_entry, head_entry;

  assign vs_rise   = vsync_q & ~vsync_prev_q;
  assign href_rise = href_q & ~href_prev_q;
  assign href_fall = ~href_q & href_prev_q;
  assign capturing = (state_q == ACTIVE) && !vsync_q;
  assign pix_done  = capturing && href_q && !href_rise && phase_q;
  assign step      = 4'd1 << decim_q;
  assign keep      = ((col_q & CW'(step - 4'd1)) == '0) && ((row_q & RW'(step - 4'd1)) == '0) &&
                     (col_q < RL_C) && (row_q < ROW_C);
  assign pix_push  = pix_done && keep;
  assign pix_data  = (mode_q == MODE_RGB565) ? {byte1_q, byte_q} : {4'h0, byte1_q[3:0], byte_q};
  assign pop_fire  = o_data_valid & i_data_ready;
  assign drop      = pix_push & fifo_full & ~pop_fire;

  always_comb begin
    push_entry      = '0;
    push_entry.sof  = sof_pend_q;
    push_entry.eol  = (col_q == RL_C - CW'(step));
    push_entry.data = pix_data;
  end

  pix_fifo_sync #(
    .T     (pix_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (pix_push),
    .din_i   (push_entry),
    .pop_i   (i_data_ready),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Head fields are masked so nothing stale leaks out while the FIFO is empty.
  assign o_data_valid = ~fifo_empty;
  assign o_data       = o_data_valid ? DW'(head_entry.data) : '0;
  assign o_sof        = o_data_valid & head_entry.sof;
  assign o_eol        = o_data_valid & head_entry.eol;
  assign o_overflow   = overflow_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_RGB444;
      decim_q      <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      byte_q       <= '0;
      byte1_q      <= '0;
      phase_q      <= 1'b0;
      sof_pend_q   <= 1'b0;
      overflow_q   <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      vsync_q      <= i_vsync;
      href_q       <= i_href;
      byte_q       <= i_pix_byte;
      vsync_prev_q <= vsync_q;
      href_prev_q  <= href_q;

      if (drop)           overflow_q <= 1'b1;
      else if (i_ovf_clr) overflow_q <= 1'b0;

      // The first byte after an href rise is always byte1, whatever was left over.
      if (href_q) begin
        if (href_rise || !phase_q) begin
          byte1_q <= byte_q;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
        end
      end

      if (pix_push) sof_pend_q <= 1'b0;
      if (pix_done && col_q != RL_C) col_q <= col_q + CW'(1);
      if (capturing && href_fall) begin
        col_q <= '0;
        if (row_q != ROW_C) row_q <= row_q + RW'(1);
      end

      case (state_q)
        IDLE:       if (i_enable) state_q <= WAIT_VS_HI;
        WAIT_VS_HI: if (vsync_q) state_q <= WAIT_VS_LO;
        WAIT_VS_LO: if (!vsync_q) begin
          state_q    <= ACTIVE;
          mode_q     <= mode_e'(i_mode);
          decim_q    <= i_decim;
          col_q      <= '0;
          row_q      <= '0;
          sof_pend_q <= 1'b1;
        end
        ACTIVE:     if (vs_rise) state_q <= i_enable ? WAIT_VS_LO : IDLE;
        default:    state_q <= IDLE;
      endcase
    end
  end

`ifdef PIX_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_q == ACTIVE && vs_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_pix_capture.sv
// Directed bench for pix_capture on a 16x8 window: formats, mode switch,
// decimation, overflow, odd/aborted rows and mid-frame reset.
module tb_pix_capture;

  localparam int RL    = 16;
  localparam int ROW   = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
`ifdef PIX_CAPTURE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [1:0]    decim = 2'd0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    pix = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          ready = 1'b1;
  logic          valid, sof, eol, overflow;
  logic [DW-1:0] data;
  logic [15:0]   frame_cnt, drop_cnt;

  pix_capture #(.RL(RL), .ROW(ROW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_mode       (mode),
    .i_decim      (decim),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_pix_byte   (pix),
    .i_ovf_clr    (ovf_clr),
    .i_data_ready (ready),
    .o_data_valid (valid),
    .o_data       (data),
    .o_sof        (sof),
    .o_eol        (eol),
    .o_overflow   (overflow),
    .o_frame_cnt  (frame_cnt),
    .o_drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_frames = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  bit          sof_pend = 1'b0;
  bit          m565 = 1'b0;
  int          step = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A pop happens at the next rising edge whenever valid & ready hold here.
  always @(negedge clk) begin
    if (!rst && valid && ready) got_q.push_back({sof, eol, data});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The DUT latches mode/decim as vsync falls, so the model does the same.
  task automatic vs_pulse();
    href  = 1'b0;
    vsync = 1'b1;
    tick(4);
    vsync = 1'b0;
    m565     = mode;
    step     = 1 << decim;
    sof_pend = 1'b1;
    tick(4);
  endtask

  task automatic send_row(input int row, input int nbytes, input bit abort);
    logic [7:0] b, b1;
    int col;
    b1   = 8'h00;
    href = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      b   = 8'($urandom_range(0, 255));
      pix = b;
      if (i % 2 == 0) begin
        b1 = b;
      end else begin
        col = i / 2;
        if (col < RL && row < ROW && col % step == 0 && row % step == 0) begin
          exp_q.push_back({sof_pend, col == RL - step, m565 ? {b1, b} : {4'h0, b1[3:0], b}});
          sof_pend = 1'b0;
        end
      end
      tick();
    end
    if (abort) begin
      vsync = 1'b1;
      tick();
    end
    href = 1'b0;
    pix  = 8'h00;
    tick(3);
  endtask

  task automatic send_frame(input int nrows, input int nbytes);
    for (int r = 0; r < nrows; r++) send_row(r, nbytes, 1'b0);
  endtask

  task automatic drain_compare(input string tag);
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 400) begin
      tick();
      guard++;
    end
    tick(4);
    check_eq($sformatf("%s count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s px%0d", tag, i), got_q[i], exp_q[i]);
    check_eq($sformatf("%s frame_cnt", tag), frame_cnt, STATS ? exp_frames : 0);
    $display("frame %s: %0d pixels expected, %0d received", tag, exp_q.size(), got_q.size());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tick(3);
    check_eq("rst valid", valid, 0);
    check_eq("rst data", data, 0);
    check_eq("rst overflow", overflow, 0);
    check_eq("rst frame_cnt", frame_cnt, 0);
    check_eq("rst drop_cnt", drop_cnt, 0);
    rst    = 1'b0;
    enable = 1'b1;
    tick(2);
    vs_pulse();

    send_frame(8, 32);
    vs_pulse();
    exp_frames++;
    drain_compare("rgb444");

    send_frame(4, 32);
    mode = 1'b1;
    for (int r = 4; r < 8; r++) send_row(r, 32, 1'b0);
    vs_pulse();
    exp_frames++;
    drain_compare("mode_switch_cur");

    send_frame(8, 32);
    mode  = 1'b0;
    decim = 2'd1;
    vs_pulse();
    exp_frames++;
    drain_compare("rgb565_next");

    send_frame(8, 32);
    decim = 2'd0;
    vs_pulse();
    exp_frames++;
    drain_compare("decim1");

    ready = 1'b0;
    send_row(0, 32, 1'b0);
    send_row(1, 8, 1'b0);
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    check_eq("ovf valid", valid, 1);
    check_eq("ovf flag", overflow, 1);
    check_eq("ovf drop_cnt", drop_cnt, STATS ? 12 : 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check_eq("ovf cleared", overflow, 0);
    check_eq("ovf drop_cnt kept", drop_cnt, STATS ? 12 : 0);
    vs_pulse();
    exp_frames++;
    ready = 1'b1;
    drain_compare("overflow");

    send_row(0, 33, 1'b0);
    send_row(1, 33, 1'b0);
    send_row(2, 10, 1'b1);
    vs_pulse();
    exp_frames++;
    drain_compare("odd_abort");
    send_frame(1, 32);
    vs_pulse();
    exp_frames++;
    drain_compare("after_abort");

    ready = 1'b0;
    send_row(0, 32, 1'b0);
    exp_q.delete();
    check_eq("pre-reset valid", valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("reset valid", valid, 0);
    check_eq("reset data", data, 0);
    check_eq("reset sof", sof, 0);
    check_eq("reset eol", eol, 0);
    check_eq("reset overflow", overflow, 0);
    check_eq("reset frame_cnt", frame_cnt, 0);
    check_eq("reset drop_cnt", drop_cnt, 0);
    tick();
    rst        = 1'b0;
    exp_frames = 0;
    ready      = 1'b1;
    sof_pend   = 1'b0;
    for (int r = 0; r < 2; r++) begin
      href = 1'b1;
      for (int i = 0; i < 32; i++) begin
        pix = 8'($urandom_range(0, 255));
        tick();
      end
      href = 1'b0;
      tick(3);
    end
    tick(4);
    check_eq("no output before vsync", got_q.size(), 0);
    got_q.delete();
    vs_pulse();
    send_frame(1, 32);
    vs_pulse();
    exp_frames++;
    drain_compare("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
